// File: rtl/prold_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prold_loader_pkg
//  Brief    : Shared widths and state encodings for the program-load producer.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef PROLD_LOADER_DEFS
`define PROLD_LOADER_DEFS
`define LEN_WORD       32
`define LEN_INST       32
`define LEN_PROLD_INFO 66
`endif

package prold_loader_pkg;

    localparam logic [1:0] S_LEN  = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/prold_loader_byte_to_word.sv
`default_nettype none
// ============================================================================
//  Module   : byte_to_word
//  Brief    : Assembles big-endian 32-bit words from a byte strobe stream.
//  Revision : 1.0 - initial release
// ============================================================================

module byte_to_word (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        clear,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] r_sh;
    logic [1:0]  r_byte_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sh       <= '0;
            r_byte_cnt <= 2'd0;
        end else if (clear) begin
            r_byte_cnt <= 2'd0;
        end else if (rx_valid) begin
            r_sh       <= {r_sh[15:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    // The completed word is presented combinationally with its last byte.
    assign word_valid = rx_valid & ~clear & (r_byte_cnt == 2'd3);
    assign word       = {r_sh, rx_data};

endmodule

`default_nettype wire

// File: rtl/prold_loader_prims.sv
`default_nettype none
// ============================================================================
//  Module   : temp_reg / pack_prold_info
//  Brief    : Enabled output register primitive and prold_info bus packer.
//  Revision : 1.0 - initial release
// ============================================================================

module temp_reg #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            o_q <= RST_VAL;
        else if (i_en)
            o_q <= i_d;
    end

endmodule

module pack_prold_info (
    input  logic                       i_mode,
    input  logic                       i_order,
    input  logic [`LEN_WORD-1:0]       i_pc,
    input  logic [`LEN_INST-1:0]       i_data,
    output logic [`LEN_PROLD_INFO-1:0] o_info
);

    assign o_info = {i_mode, i_order, i_pc, i_data};

endmodule

`default_nettype wire

// File: rtl/prold_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prold_loader
//  Brief    : Loads a UART byte-stream program image onto the prold bus.
//  Revision : 1.0 - initial release
// ============================================================================

module prold_loader
    import prold_loader_pkg::*;
#(
    parameter logic [31:0] PC_BASE  = 32'h0000_0000,
    parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    input  logic                       reload,
    output logic [`LEN_PROLD_INFO-1:0] prold_info,
    output logic                       load_done
);

    logic [1:0]  r_state;
    logic [31:0] r_word_cnt;
    logic [31:0] r_pc;

    logic        r_mode;
    logic        r_order;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_data;
    logic        r_tx_valid;
    logic        r_load_done;

    logic        w_take;
    logic        w_clear;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic        w_hs;
    logic        w_len_zero;
    logic        w_emit;
    logic        w_last_word;

    // Bytes are only consumed while the image is being received.
    assign w_take      = rx_valid & ((r_state == S_LEN) | (r_state == S_DATA));
    assign w_clear     = (r_state == S_DONE) & reload;
    assign w_hs        = (r_state == S_ACK) & r_tx_valid & tx_ready;
    assign w_len_zero  = (r_state == S_LEN) & w_word_valid & (w_word == 32'd0);
    assign w_emit      = (r_state == S_DATA) & w_word_valid;
    assign w_last_word = w_emit & (r_word_cnt == 32'd1);

    byte_to_word u_byte_to_word (
        .clk        (clk),
        .rstn       (rstn),
        .rx_valid   (w_take),
        .rx_data    (rx_data),
        .clear      (w_clear),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_LEN;
            r_word_cnt <= 32'd0;
            r_pc       <= PC_BASE;
        end else begin
            case (r_state)
                S_LEN: begin
                    if (w_word_valid) begin
                        if (w_word == 32'd0) begin
                            r_state <= S_ACK;
                        end else begin
                            r_word_cnt <= w_word;
                            r_state    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_word_valid) begin
                        r_pc       <= r_pc + 32'd4;
                        r_word_cnt <= r_word_cnt - 32'd1;
                        if (r_word_cnt == 32'd1)
                            r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (w_hs)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (reload) begin
                        r_pc    <= PC_BASE;
                        r_state <= S_LEN;
                    end
                end
                default: r_state <= S_LEN;
            endcase
        end
    end

    temp_reg #(.WIDTH(1), .RST_VAL(1'b1)) u_mode_reg (
        .clk (clk), .rstn (rstn), .i_en (1'b1),
        .i_d (w_hs ? 1'b0 : (w_clear ? 1'b1 : r_mode)),
        .o_q (r_mode)
    );

    temp_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_order_reg (
        .clk (clk), .rstn (rstn), .i_en (1'b1),
        .i_d (w_emit),
        .o_q (r_order)
    );

    temp_reg #(.WIDTH(32), .RST_VAL(PC_BASE)) u_pc_reg (
        .clk (clk), .rstn (rstn), .i_en (w_emit),
        .i_d (r_pc),
        .o_q (r_out_pc)
    );

    temp_reg #(.WIDTH(32), .RST_VAL(32'd0)) u_data_reg (
        .clk (clk), .rstn (rstn), .i_en (w_emit),
        .i_d (w_word),
        .o_q (r_out_data)
    );

    // The ack request rises together with the final order pulse, so mode
    // can fall no earlier than the cycle after that pulse.
    temp_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_tx_valid_reg (
        .clk (clk), .rstn (rstn), .i_en (1'b1),
        .i_d (w_len_zero | w_last_word | (r_tx_valid & ~w_hs)),
        .o_q (r_tx_valid)
    );

    temp_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_done_reg (
        .clk (clk), .rstn (rstn), .i_en (1'b1),
        .i_d (w_hs | (r_load_done & ~w_clear)),
        .o_q (r_load_done)
    );

    pack_prold_info u_pack (
        .i_mode  (r_mode),
        .i_order (r_order),
        .i_pc    (r_out_pc),
        .i_data  (r_out_data),
        .o_info  (prold_info)
    );

    assign tx_valid  = r_tx_valid;
    assign tx_data   = ACK_BYTE;
    assign load_done = r_load_done;

endmodule

`default_nettype wire

// File: tb/tb_prold_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prold_loader
//  Brief    : Randomised self-checking bench for prold_loader.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_prold_loader;

    localparam logic [31:0] C_PC_BASE  = 32'h0000_0000;
    localparam logic [7:0]  C_ACK_BYTE = 8'hAA;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        tx_ready = 1'b0;
    logic        reload   = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [65:0] prold_info;
    logic        load_done;

    logic        mode;
    logic        order;
    logic [31:0] out_pc;
    logic [31:0] out_data;
    assign {mode, order, out_pc, out_data} = prold_info;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ld_words[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    prold_loader #(.PC_BASE(C_PC_BASE), .ACK_BYTE(C_ACK_BYTE)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .reload     (reload),
        .prold_info (prold_info),
        .load_done  (load_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every order pulse must match the next write predicted from the byte stream.
    always @(negedge clk) begin
        if (rstn && order) begin
            if (exp_q.size() == 0) begin
                check_eq("order_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("order_cycle", 64'(cyc), 64'(e.cyc));
                check_eq("order_pc", 64'(out_pc), 64'(e.pc));
                check_eq("order_data", 64'(out_data), 64'(e.data));
                check_eq("order_mode", 64'(mode), 64'd1);
            end
        end
    end

    task automatic put_byte(input logic [7:0] b, input int gap, input bit rl, output int c);
        repeat (gap) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            reload   = 1'b0;
        end
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        reload   = rl;
        c        = cyc;
    endtask

    // Sends length N then ld_words; stop_after >= 0 truncates the byte stream.
    task automatic send_load(input logic [31:0] n, input int gapmax,
                             input int reload_idx, input int stop_after);
        logic [7:0] bytes[$];
        logic [31:0] w;
        int c;
        bytes = {};
        for (int k = 0; k < 4; k++) bytes.push_back(n[31-8*k -: 8]);
        for (int j = 0; j < ld_words.size(); j++) begin
            w = ld_words[j];
            for (int k = 0; k < 4; k++) bytes.push_back(w[31-8*k -: 8]);
        end
        for (int i = 0; i < bytes.size(); i++) begin
            if (stop_after >= 0 && i >= stop_after) break;
            put_byte(bytes[i], int'($urandom_range(gapmax, 0)), (i == reload_idx), c);
            if (i >= 4 && (i % 4) == 3)
                exp_q.push_back('{c + 1, C_PC_BASE + 32'((i - 4) / 4 * 4), ld_words[(i - 4) / 4]});
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic finish_ack(input int hold, input bit stray);
        int waited;
        waited = 0;
        @(negedge clk);
        while (tx_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #1;
        check_eq("ack_valid", 64'(tx_valid), 64'd1);
        check_eq("ack_data", 64'(tx_data), 64'(C_ACK_BYTE));
        check_eq("ack_mode", 64'(mode), 64'd1);
        check_eq("ack_no_pending", 64'(exp_q.size()), 64'd0);
        check_eq("ack_done_low", 64'(load_done), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (stray) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
            end
            @(negedge clk);
            check_eq("hold_valid", 64'(tx_valid), 64'd1);
            check_eq("hold_mode", 64'(mode), 64'd1);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check_eq("done_mode", 64'(mode), 64'd0);
        check_eq("done_flag", 64'(load_done), 64'd1);
        check_eq("done_tx_valid", 64'(tx_valid), 64'd0);
    endtask

    task automatic do_reload();
        @(posedge clk); #1;
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check_eq("reload_mode", 64'(mode), 64'd1);
        check_eq("reload_done_low", 64'(load_done), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_mode"}, 64'(mode), 64'd1);
        check_eq({tag, "_order"}, 64'(order), 64'd0);
        check_eq({tag, "_pc"}, 64'(out_pc), 64'(C_PC_BASE));
        check_eq({tag, "_data"}, 64'(out_data), 64'd0);
        check_eq({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check_eq({tag, "_tx_data"}, 64'(tx_data), 64'(C_ACK_BYTE));
        check_eq({tag, "_done"}, 64'(load_done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rstn = 1'b1;

        ld_words = {32'hDEADBEEF};
        send_load(32'd1, 0, -1, -1);
        finish_ack(0, 1'b0);

        do_reload();
        ld_words = {32'h0000_0013, 32'h1111_1111, 32'h2222_2222};
        send_load(32'd3, 0, -1, -1);
        finish_ack(0, 1'b0);

        do_reload();
        ld_words = {};
        send_load(32'd0, 0, -1, -1);
        finish_ack(0, 1'b0);

        do_reload();
        ld_words = {$urandom, $urandom};
        send_load(32'd2, 2, -1, -1);
        finish_ack(10, 1'b1);

        // Abandon a load two bytes into its second word.
        do_reload();
        ld_words = {$urandom, $urandom};
        send_load(32'd2, 0, -1, 10);
        rstn = 1'b0;
        #1;
        check_reset_values("midload_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        ld_words = {32'hCAFE_F00D};
        send_load(32'd1, 1, -1, -1);
        finish_ack(1, 1'b0);

        do_reload();
        ld_words = {32'h1234_5678};
        send_load(32'd1, 0, -1, -1);
        finish_ack(0, 1'b0);

        do_reload();
        ld_words = {$urandom, $urandom};
        send_load(32'd2, 0, 6, -1);
        finish_ack(0, 1'b0);

        for (int t = 0; t < 5; t++) begin
            int n;
            do_reload();
            n = int'($urandom_range(4, 1));
            ld_words = {};
            for (int j = 0; j < n; j++) ld_words.push_back($urandom);
            send_load(32'(n), 2, -1, -1);
            finish_ack(int'($urandom_range(3, 0)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
